// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial MSB-first transmitter feeding the sequence detectors' x input.
// Optional 1,0,1 preamble per word when SEQ_BIT_SERIALIZER_PREAMBLE_EN is defined.
module seq_bit_serializer #(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              abort,
  output logic              x,
  output logic              x_valid,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] BIT_LOAD = CNT_W'(DATA_W - 1);
  localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

`ifdef SEQ_BIT_SERIALIZER_PREAMBLE_EN
  typedef enum logic [1:0] {IDLE, PRE, SHIFT, GAP} state_t;
  logic [1:0] pre_cnt;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
`endif

  state_t            state;
  logic [DATA_W-1:0] shift_reg;
  logic [CNT_W-1:0]  bit_cnt;
  logic [3:0]        gap_cnt;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // x is registered together with the state, so the bit loaded on an edge is on the line the next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      x         <= 1'b0;
      x_valid   <= 1'b0;
      done      <= 1'b0;
`ifdef SEQ_BIT_SERIALIZER_PREAMBLE_EN
      pre_cnt   <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          x       <= 1'b0;
          x_valid <= 1'b0;
          if (in_valid) begin
            bit_cnt <= BIT_LOAD;
            x_valid <= 1'b1;
`ifdef SEQ_BIT_SERIALIZER_PREAMBLE_EN
            state     <= PRE;
            pre_cnt   <= 2'd2;
            x         <= 1'b1;
            shift_reg <= in_data;
`else
            state     <= SHIFT;
            x         <= in_data[DATA_W-1];
            shift_reg <= {in_data[DATA_W-2:0], 1'b0};
`endif
          end
        end
`ifdef SEQ_BIT_SERIALIZER_PREAMBLE_EN
        PRE: begin
          if (abort) begin
            state     <= IDLE;
            x         <= 1'b0;
            x_valid   <= 1'b0;
            shift_reg <= '0;
          end else if (pre_cnt == 2'd0) begin
            state     <= SHIFT;
            x         <= shift_reg[DATA_W-1];
            shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
          end else begin
            pre_cnt <= pre_cnt - 2'd1;
            x       <= (pre_cnt == 2'd1);
          end
        end
`endif
        SHIFT: begin
          if (abort) begin
            state     <= IDLE;
            x         <= 1'b0;
            x_valid   <= 1'b0;
            shift_reg <= '0;
          end else if (bit_cnt == '0) begin
            x       <= 1'b0;
            x_valid <= 1'b0;
            if (GAP_CYCLES > 0) begin
              state   <= GAP;
              gap_cnt <= GAP_LOAD;
            end else begin
              state <= IDLE;
            end
          end else begin
            x         <= shift_reg[DATA_W-1];
            shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
            bit_cnt   <= bit_cnt - 1'b1;
            done      <= (bit_cnt == CNT_W'(1));
          end
        end
        GAP: begin
          x       <= 1'b0;
          x_valid <= 1'b0;
          if (abort) begin
            state     <= IDLE;
            shift_reg <= '0;
          end else if (gap_cnt == 4'd0) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: begin
          state   <= IDLE;
          x       <= 1'b0;
          x_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer: one instance with a 1-cycle gap, one with no gap.
// Also covers the SEQ_BIT_SERIALIZER_PREAMBLE_EN build when that macro is defined.
module tb_seq_bit_serializer;

  logic       clk;
  logic       reset;
  logic [7:0] in_data_a, in_data_b;
  logic       in_valid_a, in_valid_b;
  logic       abort_a, abort_b;
  logic       in_ready_a, in_ready_b;
  logic       x_a, x_b;
  logic       x_valid_a, x_valid_b;
  logic       busy_a, busy_b;
  logic       done_a, done_b;

  int compared;
  int mismatched;
  int hits;
  logic [2:0] hist;
  logic [2:0] pre_pat;

  seq_bit_serializer #(.DATA_W(8), .GAP_CYCLES(1)) dut_a (
    .clk(clk), .reset(reset), .in_data(in_data_a), .in_valid(in_valid_a),
    .in_ready(in_ready_a), .abort(abort_a), .x(x_a), .x_valid(x_valid_a),
    .busy(busy_a), .done(done_a)
  );

  seq_bit_serializer #(.DATA_W(8), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .in_data(in_data_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .abort(abort_b), .x(x_b), .x_valid(x_valid_b),
    .busy(busy_b), .done(done_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic observeA();
    hist = {hist[1:0], x_a};
    if (hist == 3'b101) hits++;
  endtask

  // stop_bit < 0 sends the whole word; otherwise abort (or reset) lands while that bit index is on x.
  task automatic applyStimulus(input logic [7:0] data, input int stop_bit, input bit use_reset, input string tag);
    hist = 3'b000;
    hits = 0;
    in_data_a  = data;
    in_valid_a = 1'b1;
    tick();
    in_valid_a = 1'b0;
`ifdef SEQ_BIT_SERIALIZER_PREAMBLE_EN
    for (int p = 0; p < 3; p++) begin
      checkOutput({tag, "_pre_x"}, 32'(x_a), 32'(pre_pat[2-p]));
      checkOutput({tag, "_pre_xv"}, 32'(x_valid_a), 32'd1);
      observeA();
      tick();
    end
`endif
    for (int i = 0; i < 8; i++) begin
      checkOutput({tag, "_x"}, 32'(x_a), 32'(data[7-i]));
      checkOutput({tag, "_xv"}, 32'(x_valid_a), 32'd1);
      checkOutput({tag, "_done"}, 32'(done_a), (i == 7) ? 32'd1 : 32'd0);
      checkOutput({tag, "_rdy"}, 32'(in_ready_a), 32'd0);
      observeA();
      if (i == stop_bit) begin
        if (use_reset) begin
          #3 reset = 1'b1;
          #1;
          checkOutput({tag, "_rst_x"}, 32'(x_a), 32'd0);
          checkOutput({tag, "_rst_xv"}, 32'(x_valid_a), 32'd0);
          checkOutput({tag, "_rst_busy"}, 32'(busy_a), 32'd0);
          checkOutput({tag, "_rst_rdy"}, 32'(in_ready_a), 32'd1);
          tick();
          reset = 1'b0;
        end else begin
          abort_a = 1'b1;
          tick();
          abort_a = 1'b0;
          checkOutput({tag, "_ab_x"}, 32'(x_a), 32'd0);
          checkOutput({tag, "_ab_xv"}, 32'(x_valid_a), 32'd0);
          checkOutput({tag, "_ab_done"}, 32'(done_a), 32'd0);
          checkOutput({tag, "_ab_busy"}, 32'(busy_a), 32'd0);
          checkOutput({tag, "_ab_rdy"}, 32'(in_ready_a), 32'd1);
        end
        return;
      end
      tick();
    end
    checkOutput({tag, "_gap_xv"}, 32'(x_valid_a), 32'd0);
    checkOutput({tag, "_gap_rdy"}, 32'(in_ready_a), 32'd0);
    checkOutput({tag, "_gap_busy"}, 32'(busy_a), 32'd1);
    tick();
    checkOutput({tag, "_idle_rdy"}, 32'(in_ready_a), 32'd1);
    checkOutput({tag, "_idle_busy"}, 32'(busy_a), 32'd0);
  endtask

  // With no gap and in_valid held high, words are separated only by the IDLE accept cycle.
  task automatic runBackToBack();
    logic [7:0] word;
    int dones;
    dones = 0;
    in_data_b  = 8'hFF;
    in_valid_b = 1'b1;
    tick();
    in_data_b = 8'h00;
    for (int w = 0; w < 2; w++) begin
      word = (w == 0) ? 8'hFF : 8'h00;
`ifdef SEQ_BIT_SERIALIZER_PREAMBLE_EN
      for (int p = 0; p < 3; p++) begin
        checkOutput("b2b_pre_x", 32'(x_b), 32'(pre_pat[2-p]));
        dones += int'(done_b);
        tick();
      end
`endif
      for (int i = 0; i < 8; i++) begin
        checkOutput("b2b_x", 32'(x_b), 32'(word[7-i]));
        checkOutput("b2b_xv", 32'(x_valid_b), 32'd1);
        checkOutput("b2b_rdy", 32'(in_ready_b), 32'd0);
        dones += int'(done_b);
        tick();
      end
      if (w == 0) begin
        checkOutput("b2b_idle_xv", 32'(x_valid_b), 32'd0);
        checkOutput("b2b_idle_rdy", 32'(in_ready_b), 32'd1);
        dones += int'(done_b);
        tick();
        in_valid_b = 1'b0;
      end
    end
    checkOutput("b2b_done_count", 32'(dones), 32'd2);
    checkOutput("b2b_end_busy", 32'(busy_b), 32'd0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    hits       = 0;
    hist       = 3'b000;
    pre_pat    = 3'b101;
    reset      = 1'b1;
    in_data_a  = 8'h00;
    in_data_b  = 8'h00;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    abort_a    = 1'b0;
    abort_b    = 1'b0;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("rst_x", 32'(x_a), 32'd0);
    checkOutput("rst_xv", 32'(x_valid_a), 32'd0);
    checkOutput("rst_done", 32'(done_a), 32'd0);
    checkOutput("rst_busy", 32'(busy_a), 32'd0);
    checkOutput("rst_rdy", 32'(in_ready_a), 32'd1);
    for (int c = 0; c < 5; c++) begin
      tick();
      checkOutput("idle_xv", 32'(x_valid_a), 32'd0);
      checkOutput("idle_busy", 32'(busy_a), 32'd0);
    end

    applyStimulus(8'hA5, -1, 1'b0, "a5");
    applyStimulus(8'hC3, 2, 1'b0, "c3_abort");
    applyStimulus(8'h81, -1, 1'b0, "81");
    runBackToBack();
    applyStimulus(8'h5A, 3, 1'b1, "5a_reset");
    applyStimulus(8'h96, -1, 1'b0, "96");
`ifdef SEQ_BIT_SERIALIZER_PREAMBLE_EN
    applyStimulus(8'h00, -1, 1'b0, "pre00");
    checkOutput("pre00_101_hits", 32'(hits), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
